input_mems_db: RTL



---
 rtl/input_mems_db.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/input_mems_db.sv
// Double-buffered input store for the convolution core: one shared weight memory,
// resident K/B registers and two ping-pong X banks filled from an AXI-Stream port.
module input_mems_db #(
    parameter int INW  = 24,
    parameter int R    = 9,
    parameter int C    = 8,
    parameter int MAXK = 4,
    localparam int K_BITS      = $clog2(MAXK + 1),
    localparam int X_ADDR_BITS = $clog2(R * C),
    localparam int W_ADDR_BITS = $clog2(MAXK * MAXK)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [INW-1:0]  AXIS_TDATA,
    input  logic                   AXIS_TVALID,
    input  logic [K_BITS:0]        AXIS_TUSER,
    output logic                   AXIS_TREADY,
    output logic                   inputs_loaded,
    input  logic                   compute_finished,
    output logic [K_BITS-1:0]      K,
    output logic signed [INW-1:0]  B,
    input  logic [X_ADDR_BITS-1:0] X_read_addr,
    output logic signed [INW-1:0]  X_data,
    input  logic [W_ADDR_BITS-1:0] W_read_addr,
    output logic signed [INW-1:0]  W_data
);

    localparam int X_WORDS = R * C;
    localparam int W_WORDS = MAXK * MAXK;

    typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, LOAD_X} state_t;

    state_t state, state_next;

    logic [1:0]             full;
    logic                   wr_bank;
    logic                   rd_bank;
    logic [W_ADDR_BITS-1:0] w_cnt;
    logic [X_ADDR_BITS-1:0] x_cnt;

    logic signed [INW-1:0] w_mem [W_WORDS];
    logic signed [INW-1:0] x_mem [2][X_WORDS];

    logic              handshake;
    logic              new_w;
    logic [K_BITS-1:0] tuser_k;
    logic              w_last;
    logic              x_last;
    logic              release_rd;

    assign new_w         = AXIS_TUSER[0];
    assign tuser_k       = AXIS_TUSER[K_BITS:1];
    assign handshake     = AXIS_TVALID && AXIS_TREADY;
    assign w_last        = (32'(w_cnt) == 32'(K) * 32'(K) - 32'd1);
    assign x_last        = (x_cnt == X_ADDR_BITS'(X_WORDS - 1));
    assign release_rd    = compute_finished && full[rd_bank];
    assign inputs_loaded = full[rd_bank];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // New weights are held off until both banks have drained so compute never sees W change mid-run.
    always_comb begin
        state_next  = state;
        AXIS_TREADY = 1'b1;
        case (state)
            IDLE: begin
                AXIS_TREADY = !full[wr_bank] && !(new_w && (|full));
                if (AXIS_TVALID && AXIS_TREADY) begin
                    if (new_w) begin
                        state_next = (tuser_k == K_BITS'(1)) ? LOAD_B : LOAD_W;
                    end else begin
                        state_next = LOAD_X;
                    end
                end
            end
            LOAD_W: begin
                if (AXIS_TVALID && w_last) begin
                    state_next = LOAD_B;
                end
            end
            LOAD_B: begin
                if (AXIS_TVALID) begin
                    state_next = LOAD_X;
                end
            end
            LOAD_X: begin
                if (AXIS_TVALID && x_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            w_cnt   <= '0;
            x_cnt   <= '0;
            K       <= '0;
            B       <= '0;
        end else begin
            if (handshake) begin
                case (state)
                    IDLE: begin
                        if (new_w) begin
                            K     <= tuser_k;
                            w_cnt <= W_ADDR_BITS'(1);
                        end else begin
                            x_cnt <= X_ADDR_BITS'(1);
                        end
                    end
                    LOAD_W: w_cnt <= w_cnt + 1'b1;
                    LOAD_B: begin
                        B     <= AXIS_TDATA;
                        x_cnt <= '0;
                    end
                    LOAD_X: begin
                        x_cnt <= x_cnt + 1'b1;
                        if (x_last) begin
                            full[wr_bank] <= 1'b1;
                            wr_bank       <= !wr_bank;
                        end
                    end
                    default: ;
                endcase
            end
            // The write bank is never the full read bank, so both updates can land on one edge.
            if (release_rd) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= !rd_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (handshake && !reset) begin
            case (state)
                IDLE: begin
                    if (new_w) begin
                        w_mem[0] <= AXIS_TDATA;
                    end else begin
                        x_mem[wr_bank][0] <= AXIS_TDATA;
                    end
                end
                LOAD_W:  w_mem[w_cnt] <= AXIS_TDATA;
                LOAD_X:  x_mem[wr_bank][x_cnt] <= AXIS_TDATA;
                default: ;
            endcase
        end
    end

    // Bank select is sampled with the address so an rd_bank toggle cannot corrupt a read in flight.
    always_ff @(posedge clk) begin
        X_data <= x_mem[rd_bank][X_read_addr];
        W_data <= w_mem[W_read_addr];
    end

endmodule
